// File: rtl/conv1d_pkg.sv
// conv1d_pkg: shared definitions for the conv1d_seq engine.
//   - command codes carried on cmd_funct (funct7)
//   - controller state encoding
//   - widths of the position/tap and channel fields packed into cmd_in0
package conv1d_pkg;

  localparam logic [6:0] CMD_CLEAR      = 7'd0;
  localparam logic [6:0] CMD_WR_IN      = 7'd10;
  localparam logic [6:0] CMD_WR_KER     = 7'd11;
  localparam logic [6:0] CMD_RD_IN      = 7'd13;
  localparam logic [6:0] CMD_RD_KER     = 7'd14;
  localparam logic [6:0] CMD_SET_OFFSET = 7'd20;
  localparam logic [6:0] CMD_SET_WIDTH  = 7'd25;
  localparam logic [6:0] CMD_SET_DEPTH  = 7'd26;
  localparam logic [6:0] CMD_START      = 7'd41;
  localparam logic [6:0] CMD_SET_ORIGIN = 7'd42;
  localparam logic [6:0] CMD_RD_ACC     = 7'd43;

  // cmd_in0 = {position_or_tap[15:0], channel[15:0]}
  localparam int unsigned CMD_POS_W = 16;
  localparam int unsigned CMD_CH_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

endpackage

// File: rtl/conv1d_bank.sv
// conv1d_bank: single-port synchronous int8 RAM, one bank of a channel-banked
// memory. Read data is registered and only changes on an enabled read, so it
// stays stable while the controller holds a response.
//   clk      in   clock
//   i_en     in   port enable
//   i_we     in   write (1) / read (0) when enabled
//   i_addr   in   row address
//   i_wdata  in   byte to write
//   o_rdata  out  byte read on the previous enabled read
module conv1d_bank #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      o_rdata       <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/conv1d_seq.sv
// conv1d_seq: multi-cycle 1-D convolution engine behind a CFU-style
// command/response handshake. Holds an int8 input tile and an int8 kernel in
// LANES-wide channel-banked RAMs and computes one output point per START,
// LANES MACs per cycle, zero-padding positions outside [0, width).
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted this cycle (IDLE only)
//   cmd_funct  in   command code
//   cmd_in0    in   {pos/tap, channel}
//   cmd_in1    in   value
//   rsp_valid  out  response present, held until rsp_ready
//   rsp_ready  in   response consumed
//   rsp_data   out  response payload
//   busy       out  high while computing
//
// state   | meaning
// IDLE    | ready for a command
// COMPUTE | streaming tap/group reads through the MAC lanes
// RESP    | response held until rsp_ready
module conv1d_seq
  import conv1d_pkg::*;
#(
  parameter int unsigned KERNEL_LENGTH  = 8,
  parameter int unsigned MAX_INPUT_SIZE = 1024,
  parameter int unsigned MAX_CHANNELS   = 128,
  parameter int unsigned LANES          = 4,
  parameter int unsigned ACC_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [6:0]           cmd_funct,
  input  logic [31:0]          cmd_in0,
  input  logic [31:0]          cmd_in1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ACC_WIDTH-1:0] rsp_data,
  output logic                 busy
);

  localparam int unsigned GROUPS_MAX = MAX_CHANNELS / LANES;
  localparam int unsigned IN_ROWS    = MAX_INPUT_SIZE * GROUPS_MAX;
  localparam int unsigned KER_ROWS   = KERNEL_LENGTH * GROUPS_MAX;
  localparam int unsigned IN_AW      = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int unsigned KER_AW     = (KER_ROWS > 1) ? $clog2(KER_ROWS) : 1;
  localparam int unsigned BANK_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned TAP_W      = (KERNEL_LENGTH > 1) ? $clog2(KERNEL_LENGTH) : 1;
  localparam int unsigned GRP_W      = $clog2(GROUPS_MAX + 1);

  function automatic logic [ACC_WIDTH-1:0] sext8(input logic [7:0] b);
    return {{(ACC_WIDTH-8){b[7]}}, b};
  endfunction

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic                  r_busy;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_rsp_data;
  logic signed [31:0]    r_offset;
  logic signed [31:0]    r_origin;
  logic [31:0]           r_width;
  logic [31:0]           r_depth;
  logic [TAP_W-1:0]      r_t;
  logic [GRP_W-1:0]      r_g;
  logic                  r_issuing;
  logic                  r_p1;
  logic [LANES-1:0]      r_p1_mask;
  logic                  r_rd_active;
  logic                  r_rd_ker;
  logic [BANK_W-1:0]     r_rd_bank;

  // ---------------- command decode ----------------
  logic [31:0]       w_pos;
  logic [31:0]       w_ch;
  logic              w_accept;
  logic              w_in_ok;
  logic              w_ker_ok;
  logic              w_in_access;
  logic              w_ker_access;
  logic [BANK_W-1:0] w_cmd_bank;
  logic [IN_AW-1:0]  w_cmd_in_row;
  logic [KER_AW-1:0] w_cmd_ker_row;

  assign w_pos    = {{(32-CMD_POS_W){1'b0}}, cmd_in0[31 -: CMD_POS_W]};
  assign w_ch     = {{(32-CMD_CH_W){1'b0}}, cmd_in0[CMD_CH_W-1:0]};
  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_in_ok  = (w_pos < MAX_INPUT_SIZE) && (w_ch < MAX_CHANNELS);
  assign w_ker_ok = (w_pos < KERNEL_LENGTH) && (w_ch < MAX_CHANNELS);
  assign w_in_access  = w_in_ok && ((cmd_funct == CMD_WR_IN) || (cmd_funct == CMD_RD_IN));
  assign w_ker_access = w_ker_ok && ((cmd_funct == CMD_WR_KER) || (cmd_funct == CMD_RD_KER));
  assign w_cmd_bank    = BANK_W'(w_ch % LANES);
  assign w_cmd_in_row  = IN_AW'(w_pos * GROUPS_MAX + w_ch / LANES);
  assign w_cmd_ker_row = KER_AW'(w_pos * GROUPS_MAX + w_ch / LANES);

  // ---------------- compute addressing ----------------
  logic signed [31:0] w_x;
  logic               w_x_ok;
  logic [31:0]        w_groups;
  logic               w_last_g;
  logic               w_last_t;
  logic [IN_AW-1:0]   w_c_in_row;
  logic [KER_AW-1:0]  w_c_ker_row;
  logic [LANES-1:0]   w_lane_mask;

  assign w_x      = r_origin + $signed(32'(r_t));
  assign w_x_ok   = !w_x[31] && ($unsigned(w_x) < r_width);
  assign w_groups = (r_depth + LANES - 1) / LANES;
  assign w_last_g = (r_g == GRP_W'(w_groups - 1));
  assign w_last_t = (r_t == TAP_W'(KERNEL_LENGTH - 1));
  // Padded positions read row 0; their lanes are masked off anyway.
  assign w_c_in_row  = w_x_ok ? IN_AW'($unsigned(w_x) * GROUPS_MAX + 32'(r_g)) : '0;
  assign w_c_ker_row = KER_AW'(32'(r_t) * GROUPS_MAX + 32'(r_g));

  always_comb begin
    w_lane_mask = '0;
    for (int l = 0; l < LANES; l++)
      w_lane_mask[l] = w_x_ok && ((32'(r_g) * LANES + 32'(l)) < r_depth);
  end

  // ---------------- memory banks ----------------
  logic              w_compute;
  logic              w_we_in;
  logic              w_we_ker;
  logic [IN_AW-1:0]  w_in_addr;
  logic [KER_AW-1:0] w_ker_addr;
  logic [LANES-1:0]  w_in_en;
  logic [LANES-1:0]  w_ker_en;
  logic [7:0]        w_in_q  [LANES];
  logic [7:0]        w_ker_q [LANES];

  assign w_compute  = (r_state == COMPUTE);
  assign w_we_in    = (r_state == IDLE) && (cmd_funct == CMD_WR_IN);
  assign w_we_ker   = (r_state == IDLE) && (cmd_funct == CMD_WR_KER);
  assign w_in_addr  = w_compute ? w_c_in_row : w_cmd_in_row;
  assign w_ker_addr = w_compute ? w_c_ker_row : w_cmd_ker_row;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic w_sel;
    assign w_sel       = (w_cmd_bank == BANK_W'(l));
    assign w_in_en[l]  = w_compute ? r_issuing : (w_accept && w_in_access && w_sel);
    assign w_ker_en[l] = w_compute ? r_issuing : (w_accept && w_ker_access && w_sel);

    conv1d_bank #(.DEPTH(IN_ROWS)) u_in_bank (
      .clk     (clk),
      .i_en    (w_in_en[l]),
      .i_we    (w_we_in),
      .i_addr  (w_in_addr),
      .i_wdata (cmd_in1[7:0]),
      .o_rdata (w_in_q[l])
    );

    conv1d_bank #(.DEPTH(KER_ROWS)) u_ker_bank (
      .clk     (clk),
      .i_en    (w_ker_en[l]),
      .i_we    (w_we_ker),
      .i_addr  (w_ker_addr),
      .i_wdata (cmd_in1[7:0]),
      .o_rdata (w_ker_q[l])
    );
  end

  // ---------------- MAC lanes ----------------
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;

  always_comb begin
    w_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (r_p1 && r_p1_mask[l])
        w_sum = w_sum + sext8(w_ker_q[l]) * (sext8(w_in_q[l]) + ACC_WIDTH'(r_offset));
    end
  end

  assign w_acc_next = r_acc + w_sum;

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_acc       <= '0;
      r_rsp_data  <= '0;
      r_offset    <= '0;
      r_origin    <= '0;
      r_width     <= '0;
      r_depth     <= '0;
      r_t         <= '0;
      r_g         <= '0;
      r_issuing   <= 1'b0;
      r_p1        <= 1'b0;
      r_p1_mask   <= '0;
      r_rd_active <= 1'b0;
      r_rd_ker    <= 1'b0;
      r_rd_bank   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rd_active <= 1'b0;
            r_rsp_data  <= '0;
            r_rd_bank   <= w_cmd_bank;
            case (cmd_funct)
              CMD_CLEAR: begin
                r_acc    <= '0;
                r_offset <= '0;
                r_origin <= '0;
                r_width  <= '0;
                r_depth  <= '0;
              end
              CMD_RD_IN: begin
                r_rd_active <= w_in_ok;
                r_rd_ker    <= 1'b0;
              end
              CMD_RD_KER: begin
                r_rd_active <= w_ker_ok;
                r_rd_ker    <= 1'b1;
              end
              CMD_SET_OFFSET: r_offset <= $signed(cmd_in1);
              CMD_SET_WIDTH:  r_width  <= (cmd_in1 > MAX_INPUT_SIZE) ? MAX_INPUT_SIZE : cmd_in1;
              CMD_SET_DEPTH:  r_depth  <= (cmd_in1 > MAX_CHANNELS) ? MAX_CHANNELS : cmd_in1;
              CMD_SET_ORIGIN: r_origin <= $signed(cmd_in1);
              CMD_RD_ACC:     r_rsp_data <= r_acc;
              CMD_START: begin
                r_acc     <= '0;
                r_t       <= '0;
                r_g       <= '0;
                r_issuing <= (r_depth != 0);
                r_p1      <= 1'b0;
              end
              default: ;
            endcase
            r_cmd_ready <= 1'b0;
            if (cmd_funct == CMD_START) begin
              r_state <= COMPUTE;
              r_busy  <= 1'b1;
            end else begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end
          end
        end

        COMPUTE: begin
          // Stage 1: RAM read of the issued (tap, group); stage 2: MAC + accumulate.
          r_p1      <= r_issuing;
          r_p1_mask <= w_lane_mask;
          r_acc     <= w_acc_next;
          if (r_issuing) begin
            if (w_last_g) begin
              r_g <= '0;
              if (w_last_t) r_issuing <= 1'b0;
              else          r_t       <= r_t + 1'b1;
            end else begin
              r_g <= r_g + 1'b1;
            end
          end else begin
            // Issue finished last cycle: this edge retires the final group.
            r_rsp_data  <= w_acc_next;
            r_state     <= RESP;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rd_active <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Reads return the bank's registered output, which holds while in RESP.
  logic [7:0] w_rd_byte;
  assign w_rd_byte = r_rd_ker ? w_ker_q[r_rd_bank] : w_in_q[r_rd_bank];

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign busy      = r_busy;
  assign rsp_data  = r_rd_active ? sext8(w_rd_byte) : r_rsp_data;

endmodule

// File: tb/tb_conv1d_seq.sv
module tb_conv1d_seq;

  localparam logic [6:0] C_CLEAR  = 7'd0;
  localparam logic [6:0] C_WR_IN  = 7'd10;
  localparam logic [6:0] C_WR_KER = 7'd11;
  localparam logic [6:0] C_RD_IN  = 7'd13;
  localparam logic [6:0] C_RD_KER = 7'd14;
  localparam logic [6:0] C_OFFSET = 7'd20;
  localparam logic [6:0] C_WIDTH  = 7'd25;
  localparam logic [6:0] C_DEPTH  = 7'd26;
  localparam logic [6:0] C_START  = 7'd41;
  localparam logic [6:0] C_ORIGIN = 7'd42;
  localparam logic [6:0] C_RD_ACC = 7'd43;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_funct;
  logic [31:0] cmd_in0;
  logic [31:0] cmd_in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  conv1d_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_funct (cmd_funct),
    .cmd_in0   (cmd_in0),
    .cmd_in1   (cmd_in1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one command, wait for its response, then complete the handshake.
  // lat counts clock edges from the accepting edge up to the first rsp_valid.
  task automatic do_cmd(input logic [6:0] f, input logic [31:0] a0, input logic [31:0] a1,
                        output logic [31:0] data, output int lat, output bit busy_ok);
    int n;
    cmd_valid = 1'b1;
    cmd_funct = f;
    cmd_in0   = a0;
    cmd_in1   = a1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!rsp_valid && lat < 2000) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    data = rsp_data;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  function automatic logic [31:0] addr(input int pos, input int ch);
    return {16'(pos), 16'(ch)};
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] held;
    int          lat;
    bit          bo;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_funct = '0;
    cmd_in0   = '0;
    cmd_in1   = '0;
    rsp_ready = 1'b0;
    #12;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_rsp_data",  rsp_data,       32'd0);
    #11 reset_n = 1'b1;
    @(posedge clk); #1;

    // Bounds and sign extension
    do_cmd(C_WR_IN, addr(0, 128), 32'd5, d, lat, bo);
    check("wr_rsp_zero", d, 32'd0);
    check("wr_latency", 32'(lat), 32'd1);
    do_cmd(C_RD_IN, addr(0, 128), 32'd0, d, lat, bo);
    check("rd_in_ch128", d, 32'd0);
    do_cmd(C_WR_IN, addr(3, 5), 32'h80, d, lat, bo);
    do_cmd(C_RD_IN, addr(3, 5), 32'd0, d, lat, bo);
    check("rd_in_sext", d, 32'hFFFF_FF80);
    do_cmd(C_WR_KER, addr(8, 0), 32'd7, d, lat, bo);
    do_cmd(C_RD_KER, addr(8, 0), 32'd0, d, lat, bo);
    check("rd_ker_tap8", d, 32'd0);
    do_cmd(7'd99, addr(1, 1), 32'd123, d, lat, bo);
    check("unknown_cmd", d, 32'd0);

    // Input: x=0..15, ch 0..5 = 1; kernel: taps 0..7, ch 0..5 = 2
    for (int x = 0; x < 16; x++)
      for (int c = 0; c < 6; c++)
        do_cmd(C_WR_IN, addr(x, c), 32'd1, d, lat, bo);
    for (int t = 0; t < 8; t++)
      for (int c = 0; c < 6; c++)
        do_cmd(C_WR_KER, addr(t, c), 32'd2, d, lat, bo);
    do_cmd(C_RD_IN, addr(7, 2), 32'd0, d, lat, bo);
    check("rd_in_fill", d, 32'd1);
    do_cmd(C_RD_KER, addr(5, 3), 32'd0, d, lat, bo);
    check("rd_ker_fill", d, 32'd2);

    do_cmd(C_WIDTH,  32'd0, 32'd16,  d, lat, bo);
    do_cmd(C_DEPTH,  32'd0, 32'd4,   d, lat, bo);
    do_cmd(C_OFFSET, 32'd0, 32'd128, d, lat, bo);
    do_cmd(C_ORIGIN, 32'd0, 32'd0,   d, lat, bo);
    check("set_rsp_zero", d, 32'd0);

    // 8 taps * 4 lanes * 2*(1+128) = 8256
    do_cmd(C_START, 32'd0, 32'd0, d, lat, bo);
    check("start_o0_data", d, 32'd8256);
    check("start_o0_lat", 32'(lat), 32'd10);
    check("start_o0_busy", 32'(bo), 32'd1);
    do_cmd(C_RD_ACC, 32'd0, 32'd0, d, lat, bo);
    check("rd_acc_after_start", d, 32'd8256);

    do_cmd(C_ORIGIN, 32'd0, 32'hFFFF_FFFC, d, lat, bo);
    do_cmd(C_START, 32'd0, 32'd0, d, lat, bo);
    check("start_om4_data", d, 32'd4128);
    check("start_om4_lat", 32'(lat), 32'd10);

    do_cmd(C_ORIGIN, 32'd0, 32'd12, d, lat, bo);
    do_cmd(C_START, 32'd0, 32'd0, d, lat, bo);
    check("start_o12_data", d, 32'd4128);

    do_cmd(C_ORIGIN, 32'd0, 32'd16, d, lat, bo);
    do_cmd(C_START, 32'd0, 32'd0, d, lat, bo);
    check("start_o16_data", d, 32'd0);
    check("start_o16_lat", 32'(lat), 32'd10);

    // 6 channels over two groups: 8*6*258 = 12384, latency 8*2+2
    do_cmd(C_ORIGIN, 32'd0, 32'd0, d, lat, bo);
    do_cmd(C_DEPTH, 32'd0, 32'd6, d, lat, bo);
    do_cmd(C_START, 32'd0, 32'd0, d, lat, bo);
    check("start_d6_data", d, 32'd12384);
    check("start_d6_lat", 32'(lat), 32'd18);

    // depth clamps to 128 -> 32 groups -> 8*32+2
    do_cmd(C_DEPTH, 32'd0, 32'd200, d, lat, bo);
    do_cmd(C_START, 32'd0, 32'd0, d, lat, bo);
    check("start_d200_lat", 32'(lat), 32'd258);
    check("start_d200_busy", 32'(bo), 32'd1);

    // CLEAR zeroes parameters: depth 0 -> latency 2, result 0
    do_cmd(C_CLEAR, 32'd0, 32'd0, d, lat, bo);
    check("clear_rsp", d, 32'd0);
    do_cmd(C_RD_ACC, 32'd0, 32'd0, d, lat, bo);
    check("clear_acc", d, 32'd0);
    do_cmd(C_START, 32'd0, 32'd0, d, lat, bo);
    check("start_d0_data", d, 32'd0);
    check("start_d0_lat", 32'(lat), 32'd2);

    // Backpressure
    do_cmd(C_WIDTH,  32'd0, 32'd16,  d, lat, bo);
    do_cmd(C_DEPTH,  32'd0, 32'd4,   d, lat, bo);
    do_cmd(C_OFFSET, 32'd0, 32'd128, d, lat, bo);
    cmd_valid = 1'b1;
    cmd_funct = C_START;
    cmd_in0   = '0;
    cmd_in1   = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_lat", 32'(lat), 32'd10);
    held = rsp_data;
    check("bp_data", held, 32'd8256);
    cmd_valid = 1'b1;
    cmd_funct = C_RD_ACC;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_stable", rsp_data, 32'd8256);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp_second_valid", 32'(rsp_valid), 32'd1);
    check("bp_second_data", rsp_data, 32'd8256);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset during cycle 3 of a START
    cmd_valid = 1'b1;
    cmd_funct = C_START;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    do_cmd(C_RD_ACC, 32'd0, 32'd0, d, lat, bo);
    check("mid_rst_acc", d, 32'd0);
    do_cmd(C_START, 32'd0, 32'd0, d, lat, bo);
    check("post_rst_start_lat", 32'(lat), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
